// File: rtl/openhw_tlb_sa.sv
// Set-associative TLB with tree-PLRU replacement that refills misses from a page-table walker.
// Define TLB_ASID_FLUSH_EN to let flush_asid_only_i restrict a flush to non-global entries of one ASID.
module openhw_tlb_sa #(
    parameter int unsigned VPN_BITS  = 27,
    parameter int unsigned PPN_BITS  = 44,
    parameter int unsigned ASID_BITS = 16,
    parameter int unsigned SETS      = 4,
    parameter int unsigned WAYS      = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 lookup_valid_i,
    output logic                 lookup_ready_o,
    input  logic [VPN_BITS-1:0]  lookup_vpn_i,
    input  logic [ASID_BITS-1:0] lookup_asid_i,
    output logic                 resp_valid_o,
    output logic                 resp_hit_o,
    output logic [PPN_BITS-1:0]  resp_ppn_o,
    output logic [7:0]           resp_perm_o,
    output logic                 walk_req_valid_o,
    input  logic                 walk_req_ready_i,
    output logic [VPN_BITS-1:0]  walk_req_vpn_o,
    input  logic                 walk_resp_valid_i,
    input  logic [PPN_BITS-1:0]  walk_resp_ppn_i,
    input  logic [7:0]           walk_resp_perm_i,
    input  logic                 walk_resp_fault_i,
    input  logic                 flush_valid_i,
    input  logic                 flush_asid_only_i,
    input  logic [ASID_BITS-1:0] flush_asid_i
);
    localparam int unsigned IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned G_BIT = 5;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT} state_e;

    state_e               state_q, state_d;
    logic                 discard_q, discard_d;
    logic [VPN_BITS-1:0]  req_vpn_q;
    logic [ASID_BITS-1:0] req_asid_q;

    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-2:0]      plru_q  [SETS];
    logic [VPN_BITS-1:0]  tag_q   [SETS][WAYS];
    logic [ASID_BITS-1:0] asid_q  [SETS][WAYS];
    logic [PPN_BITS-1:0]  ppn_q   [SETS][WAYS];
    logic [7:0]           perm_q  [SETS][WAYS];

    logic [IDX_W-1:0]     set_idx;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     victim;
    logic                 hit_upd;
    logic                 fill_en;
    logic [WAYS-1:0]      flush_kill [SETS];

    function automatic logic [IDX_W-1:0] setOf(input logic [VPN_BITS-1:0] vpn);
        if (SETS > 1) return vpn[IDX_W-1:0];
        else          return '0;
    endfunction

    // Each tree node bit names the subtree holding the next victim (0 = lower half).
    function automatic logic [WAY_W-1:0] plruVictim(input logic [WAYS-2:0] bits);
        int unsigned      node;
        logic             b;
        logic [WAY_W-1:0] v;
        node = 0;
        v    = '0;
        for (int l = 0; l < int'(WAY_W); l++) begin
            b    = bits[WAY_W'(node)];
            v    = WAY_W'({v, b});
            node = 2 * node + (b ? 32'd2 : 32'd1);
        end
        return v;
    endfunction

    function automatic logic [WAYS-2:0] plruTouch(input logic [WAYS-2:0] bits,
                                                  input logic [WAY_W-1:0] way);
        int unsigned     node;
        logic            b;
        logic [WAYS-2:0] r;
        r    = bits;
        node = 0;
        for (int l = 0; l < int'(WAY_W); l++) begin
            b                = way[WAY_W'(int'(WAY_W) - 1 - l)];
            r[WAY_W'(node)]  = ~b;
            node             = 2 * node + (b ? 32'd2 : 32'd1);
        end
        return r;
    endfunction

    assign lookup_ready_o = (state_q == IDLE) && !flush_valid_i;

    always_comb begin
        set_idx = setOf(req_vpn_q);
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_vpn_q) &&
                ((asid_q[set_idx][w] == req_asid_q) || perm_q[set_idx][w][G_BIT])) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest-index invalid way wins over the PLRU choice.
    always_comb begin
        victim = plruVictim(plru_q[set_idx]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) victim = WAY_W'(w);
        end
    end

    always_comb begin
        for (int s = 0; s < int'(SETS); s++) begin
            flush_kill[s] = '0;
            for (int w = 0; w < int'(WAYS); w++) begin
`ifdef TLB_ASID_FLUSH_EN
                flush_kill[s][w] = flush_valid_i &&
                    (!flush_asid_only_i ||
                     (!perm_q[s][w][G_BIT] && (asid_q[s][w] == flush_asid_i)));
`else
                flush_kill[s][w] = flush_valid_i;
`endif
            end
        end
    end

`ifndef TLB_ASID_FLUSH_EN
    logic unused_flush_sel;
    assign unused_flush_sel = ^{flush_asid_only_i, flush_asid_i};
`endif

    assign hit_upd = (state_q == LOOKUP) && hit && !flush_valid_i;
    assign fill_en = (state_q == MISS_WAIT) && walk_resp_valid_i && !walk_resp_fault_i &&
                     !discard_q && !flush_valid_i;

    always_comb begin
        state_d          = state_q;
        discard_d        = discard_q;
        resp_valid_o     = 1'b0;
        resp_hit_o       = 1'b0;
        resp_ppn_o       = '0;
        resp_perm_o      = '0;
        walk_req_valid_o = 1'b0;
        walk_req_vpn_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (lookup_valid_i && lookup_ready_o) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid_o = 1'b1;
                    resp_hit_o   = 1'b1;
                    resp_ppn_o   = ppn_q[set_idx][hit_way];
                    resp_perm_o  = perm_q[set_idx][hit_way];
                    state_d      = IDLE;
                end else begin
                    discard_d = 1'b0;
                    state_d   = MISS_REQ;
                end
            end
            MISS_REQ: begin
                walk_req_valid_o = 1'b1;
                walk_req_vpn_o   = req_vpn_q;
                if (flush_valid_i) discard_d = 1'b1;
                if (walk_req_ready_i) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (flush_valid_i) discard_d = 1'b1;
                if (walk_resp_valid_i) begin
                    resp_valid_o = 1'b1;
                    if (!walk_resp_fault_i) begin
                        resp_hit_o  = 1'b1;
                        resp_ppn_o  = walk_resp_ppn_i;
                        resp_perm_o = walk_resp_perm_i;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            discard_q  <= 1'b0;
            req_vpn_q  <= '0;
            req_asid_q <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (lookup_valid_i && lookup_ready_o) begin
                req_vpn_q  <= lookup_vpn_i;
                req_asid_q <= lookup_asid_i;
            end
        end
    end

    // A fill never coincides with a flush, so the two valid-bit updates cannot collide.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (hit_upd) plru_q[set_idx] <= plruTouch(plru_q[set_idx], hit_way);
            if (fill_en) begin
                valid_q[set_idx][victim] <= 1'b1;
                plru_q[set_idx]          <= plruTouch(plru_q[set_idx], victim);
            end else begin
                for (int s = 0; s < int'(SETS); s++) valid_q[s] <= valid_q[s] & ~flush_kill[s];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_q[set_idx][victim]  <= req_vpn_q;
            asid_q[set_idx][victim] <= req_asid_q;
            ppn_q[set_idx][victim]  <= walk_resp_ppn_i;
            perm_q[set_idx][victim] <= walk_resp_perm_i;
        end
    end

endmodule

// File: tb/tb_openhw_tlb_sa.sv
// Directed self-checking bench for openhw_tlb_sa: vector table plus hand sequences for
// eviction, flush corner cases and reset during a walk (ASID flush expectations follow TLB_ASID_FLUSH_EN).
module tb_openhw_tlb_sa;
`ifdef TLB_ASID_FLUSH_EN
    localparam bit ASID_FLUSH = 1'b1;
`else
    localparam bit ASID_FLUSH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic        lookupValid;
    logic        lookupReady;
    logic [26:0] lookupVpn;
    logic [15:0] lookupAsid;
    logic        respValid;
    logic        respHit;
    logic [43:0] respPpn;
    logic [7:0]  respPerm;
    logic        walkReqValid;
    logic        walkReqReady;
    logic [26:0] walkReqVpn;
    logic        walkRespValid;
    logic [43:0] walkRespPpn;
    logic [7:0]  walkRespPerm;
    logic        walkRespFault;
    logic        flushValid;
    logic        flushAsidOnly;
    logic [15:0] flushAsid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [26:0] vpn;
        logic [15:0] asid;
        logic [43:0] wPpn;
        logic [7:0]  wPerm;
        bit          wFault;
        bit          expWalk;
        bit          expHit;
        logic [43:0] expPpn;
        logic [7:0]  expPerm;
    } vec_t;

    vec_t vecs [12];

    openhw_tlb_sa dut (
        .clk_i             (clk),
        .reset_i           (resetN),
        .lookup_valid_i    (lookupValid),
        .lookup_ready_o    (lookupReady),
        .lookup_vpn_i      (lookupVpn),
        .lookup_asid_i     (lookupAsid),
        .resp_valid_o      (respValid),
        .resp_hit_o        (respHit),
        .resp_ppn_o        (respPpn),
        .resp_perm_o       (respPerm),
        .walk_req_valid_o  (walkReqValid),
        .walk_req_ready_i  (walkReqReady),
        .walk_req_vpn_o    (walkReqVpn),
        .walk_resp_valid_i (walkRespValid),
        .walk_resp_ppn_i   (walkRespPpn),
        .walk_resp_perm_i  (walkRespPerm),
        .walk_resp_fault_i (walkRespFault),
        .flush_valid_i     (flushValid),
        .flush_asid_only_i (flushAsidOnly),
        .flush_asid_i      (flushAsid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One translation: accept, then serve the walker if it asks; flushAt 1 = flush in LOOKUP, 2 = in MISS_WAIT.
    task automatic applyStimulus(input logic [26:0] vpn, input logic [15:0] asid,
                                 input logic [43:0] wPpn, input logic [7:0] wPerm,
                                 input bit wFault, input int flushAt,
                                 output bit gotWalk, output logic [26:0] gotWalkVpn,
                                 output bit gotResp, output bit gotHit,
                                 output logic [43:0] gotPpn, output logic [7:0] gotPerm);
        int budget;
        gotWalk    = 1'b0;
        gotWalkVpn = '0;
        gotResp    = 1'b0;
        gotHit     = 1'b0;
        gotPpn     = '0;
        gotPerm    = '0;
        budget     = 0;
        while (!lookupReady && budget < 20) begin
            tick();
            budget++;
        end
        lookupValid = 1'b1;
        lookupVpn   = vpn;
        lookupAsid  = asid;
        tick();
        lookupValid = 1'b0;
        if (flushAt == 1) flushValid = 1'b1;
        #1;
        if (respValid) begin
            gotResp = 1'b1;
            gotHit  = respHit;
            gotPpn  = respPpn;
            gotPerm = respPerm;
            tick();
            flushValid = 1'b0;
        end else begin
            tick();
            flushValid = 1'b0;
            budget = 0;
            while (!walkReqValid && budget < 20) begin
                tick();
                budget++;
            end
            if (walkReqValid) begin
                gotWalk      = 1'b1;
                gotWalkVpn   = walkReqVpn;
                walkReqReady = 1'b1;
                tick();
                walkReqReady = 1'b0;
                if (flushAt == 2) begin
                    flushValid = 1'b1;
                    tick();
                    flushValid = 1'b0;
                end
                tick();
                walkRespValid = 1'b1;
                walkRespPpn   = wPpn;
                walkRespPerm  = wPerm;
                walkRespFault = wFault;
                #1;
                if (respValid) begin
                    gotResp = 1'b1;
                    gotHit  = respHit;
                    gotPpn  = respPpn;
                    gotPerm = respPerm;
                end
                tick();
                walkRespValid = 1'b0;
                walkRespPpn   = '0;
                walkRespPerm  = '0;
                walkRespFault = 1'b0;
            end
        end
    endtask

    task automatic expectTxn(input string name, input logic [26:0] vpn, input logic [15:0] asid,
                             input logic [43:0] wPpn, input logic [7:0] wPerm, input bit wFault,
                             input int flushAt, input bit expWalk, input bit expHit,
                             input logic [43:0] expPpn, input logic [7:0] expPerm);
        bit          gWalk, gResp, gHit;
        logic [26:0] gVpn;
        logic [43:0] gPpn;
        logic [7:0]  gPerm;
        applyStimulus(vpn, asid, wPpn, wPerm, wFault, flushAt, gWalk, gVpn, gResp, gHit, gPpn, gPerm);
        checkOutput({name, ".resp"}, 64'(gResp), 64'(1'b1));
        checkOutput({name, ".walk"}, 64'(gWalk), 64'(expWalk));
        if (expWalk) checkOutput({name, ".walkVpn"}, 64'(gVpn), 64'(vpn));
        checkOutput({name, ".hit"}, 64'(gHit), 64'(expHit));
        checkOutput({name, ".ppn"}, 64'(gPpn), 64'(expPpn));
        checkOutput({name, ".perm"}, 64'(gPerm), 64'(expPerm));
        checkOutput({name, ".pulse"}, 64'(respValid), 64'(1'b0));
    endtask

    task automatic doReset();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        #1;
    endtask

    initial begin
        lookupValid   = 1'b0;
        lookupVpn     = '0;
        lookupAsid    = '0;
        walkReqReady  = 1'b0;
        walkRespValid = 1'b0;
        walkRespPpn   = '0;
        walkRespPerm  = '0;
        walkRespFault = 1'b0;
        flushValid    = 1'b0;
        flushAsidOnly = 1'b0;
        flushAsid     = '0;

        // perm 0xCF has G=0, 0xEF has G=1; set index is vpn[1:0].
        vecs[0]  = '{27'h10,      16'd1,      44'hABCDE,       8'hCF, 1'b0, 1'b1, 1'b1, 44'hABCDE,       8'hCF};
        vecs[1]  = '{27'h10,      16'd1,      44'h0,           8'h00, 1'b0, 1'b0, 1'b1, 44'hABCDE,       8'hCF};
        vecs[2]  = '{27'h20,      16'd1,      44'h0,           8'h00, 1'b1, 1'b1, 1'b0, 44'h0,           8'h00};
        vecs[3]  = '{27'h20,      16'd1,      44'h22222,       8'hC7, 1'b0, 1'b1, 1'b1, 44'h22222,       8'hC7};
        vecs[4]  = '{27'h10,      16'd2,      44'h12345,       8'hCF, 1'b0, 1'b1, 1'b1, 44'h12345,       8'hCF};
        vecs[5]  = '{27'h10,      16'd1,      44'h0,           8'h00, 1'b0, 1'b0, 1'b1, 44'hABCDE,       8'hCF};
        vecs[6]  = '{27'h10,      16'd2,      44'h0,           8'h00, 1'b0, 1'b0, 1'b1, 44'h12345,       8'hCF};
        vecs[7]  = '{27'h101,     16'd3,      44'h55555,       8'hEF, 1'b0, 1'b1, 1'b1, 44'h55555,       8'hEF};
        vecs[8]  = '{27'h101,     16'd7,      44'h0,           8'h00, 1'b0, 1'b0, 1'b1, 44'h55555,       8'hEF};
        vecs[9]  = '{27'h7FFFFFF, 16'hFFFF,   44'hFFFFFFFFFFF, 8'hFF, 1'b0, 1'b1, 1'b1, 44'hFFFFFFFFFFF, 8'hFF};
        vecs[10] = '{27'h7FFFFFF, 16'hFFFF,   44'h0,           8'h00, 1'b0, 1'b0, 1'b1, 44'hFFFFFFFFFFF, 8'hFF};
        vecs[11] = '{27'h7FFFFFB, 16'hFFFF,   44'h00001,       8'h03, 1'b0, 1'b1, 1'b1, 44'h00001,       8'h03};

        doReset();
        checkOutput("rst.ready",   64'(lookupReady),  64'(1'b1));
        checkOutput("rst.resp",    64'(respValid),    64'(1'b0));
        checkOutput("rst.walkReq", 64'(walkReqValid), 64'(1'b0));
        checkOutput("rst.ppn",     64'(respPpn),      64'h0);
        checkOutput("rst.perm",    64'(respPerm),     64'h0);

        for (int i = 0; i < 12; i++) begin
            expectTxn($sformatf("vec%0d", i), vecs[i].vpn, vecs[i].asid, vecs[i].wPpn, vecs[i].wPerm,
                      vecs[i].wFault, 0, vecs[i].expWalk, vecs[i].expHit, vecs[i].expPpn, vecs[i].expPerm);
        end

        // Four fills occupy set 0; the fifth must evict the PLRU victim, way 0 holding VPN 0x0.
        doReset();
        for (int i = 0; i < 5; i++) begin
            expectTxn($sformatf("fill%0d", i), 27'(4 * i), 16'd1, 44'(32'h100 + 4 * i), 8'hCF, 1'b0,
                      0, 1'b1, 1'b1, 44'(32'h100 + 4 * i), 8'hCF);
        end
        expectTxn("evict.hit10", 27'h10, 16'd1, 44'h0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 44'h110, 8'hCF);
        expectTxn("evict.hitC",  27'hC,  16'd1, 44'h0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 44'h10C, 8'hCF);
        expectTxn("evict.miss0", 27'h0,  16'd1, 44'h200, 8'hCF, 1'b0, 0, 1'b1, 1'b1, 44'h200, 8'hCF);

        // Flush in LOOKUP still answers from old contents; afterwards the entry is gone.
        expectTxn("flushLk.hit",  27'h10, 16'd1, 44'h0,   8'h00, 1'b0, 1, 1'b0, 1'b1, 44'h110, 8'hCF);
        expectTxn("flushLk.miss", 27'h10, 16'd1, 44'h110, 8'hCF, 1'b0, 0, 1'b1, 1'b1, 44'h110, 8'hCF);

        // Flush in MISS_WAIT: walker data is returned but not installed.
        expectTxn("flushWt.resp", 27'h80, 16'd1, 44'h8080, 8'hCF, 1'b0, 2, 1'b1, 1'b1, 44'h8080, 8'hCF);
        expectTxn("flushWt.miss", 27'h80, 16'd1, 44'h8081, 8'hCF, 1'b0, 0, 1'b1, 1'b1, 44'h8081, 8'hCF);

        // Reset while requesting a walk abandons it and empties the TLB.
        expectTxn("preRst.fill", 27'h10, 16'd1, 44'h110, 8'hCF, 1'b0, 0, 1'b1, 1'b1, 44'h110, 8'hCF);
        lookupValid = 1'b1;
        lookupVpn   = 27'h40;
        lookupAsid  = 16'd1;
        tick();
        lookupValid = 1'b0;
        tick();
        checkOutput("midWalk.req",    64'(walkReqValid), 64'(1'b1));
        checkOutput("midWalk.vpn",    64'(walkReqVpn),   64'h40);
        tick();
        checkOutput("midWalk.held",   64'(walkReqValid), 64'(1'b1));
        checkOutput("midWalk.stable", 64'(walkReqVpn),   64'h40);
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        #1;
        checkOutput("midWalk.reqLow", 64'(walkReqValid), 64'(1'b0));
        checkOutput("midWalk.ready",  64'(lookupReady),  64'(1'b1));
        walkRespValid = 1'b1;
        walkRespPpn   = 44'h999;
        walkRespPerm  = 8'hCF;
        #1;
        checkOutput("midWalk.staleResp", 64'(respValid), 64'(1'b0));
        tick();
        walkRespValid = 1'b0;
        walkRespPpn   = '0;
        walkRespPerm  = '0;
        expectTxn("postRst.miss", 27'h10, 16'd1, 44'h210, 8'hCF, 1'b0, 0, 1'b1, 1'b1, 44'h210, 8'hCF);

        // ASID-qualified flush: only the non-global ASID 1 entry goes when the feature is built in.
        expectTxn("asid.fillA", 27'h1, 16'd1, 44'h111, 8'hCF, 1'b0, 0, 1'b1, 1'b1, 44'h111, 8'hCF);
        expectTxn("asid.fillB", 27'h5, 16'd2, 44'h555, 8'hCF, 1'b0, 0, 1'b1, 1'b1, 44'h555, 8'hCF);
        expectTxn("asid.fillG", 27'h9, 16'd1, 44'h999, 8'hEF, 1'b0, 0, 1'b1, 1'b1, 44'h999, 8'hEF);
        flushValid    = 1'b1;
        flushAsidOnly = 1'b1;
        flushAsid     = 16'd1;
        #1;
        checkOutput("asid.readyLow", 64'(lookupReady), 64'(1'b0));
        tick();
        flushValid    = 1'b0;
        flushAsidOnly = 1'b0;
        flushAsid     = '0;
        expectTxn("asid.lookB", 27'h5, 16'd2, 44'h555, 8'hCF, 1'b0, 0, !ASID_FLUSH, 1'b1, 44'h555, 8'hCF);
        expectTxn("asid.lookG", 27'h9, 16'd1, 44'h999, 8'hEF, 1'b0, 0, !ASID_FLUSH, 1'b1, 44'h999, 8'hEF);
        expectTxn("asid.lookA", 27'h1, 16'd1, 44'h111, 8'hCF, 1'b0, 0, 1'b1,        1'b1, 44'h111, 8'hCF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/openhw_tlb_sa.md
OPENHW_TLB_SA -- requirements
Module: openhw_tlb_sa

Interface
REQ-001 Parameter VPN_BITS, 27, virtual page number width (Sv39, 4 KiB pages only).
REQ-002 Parameter PPN_BITS, 44, physical page number width.
REQ-003 Parameter ASID_BITS, 16, address-space identifier width.
REQ-004 Parameter SETS, 4, number of sets, power of two, >=1.
REQ-005 Parameter WAYS, 4, ways per set, power of two, >=2.
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 reset  in  1  synchronous active-low reset (0 = reset).
REQ-008 lookup_valid  in  1  translation request; lookup_ready  out  1  request accepted when both high.
REQ-009 lookup_vpn  in  VPN_BITS; lookup_asid  in  ASID_BITS  request tag.
REQ-010 resp_valid  out  1  one-cycle response pulse; resp_hit  out  1  1 = translation valid, 0 = walker fault.
REQ-011 resp_ppn  out  PPN_BITS; resp_perm  out  8  PTE bits {D,A,G,U,X,W,R,V}.
REQ-012 walk_req_valid  out  1; walk_req_ready  in  1; walk_req_vpn  out  VPN_BITS  refill request to page-table walker.
REQ-013 walk_resp_valid  in  1; walk_resp_ppn  in  PPN_BITS; walk_resp_perm  in  8; walk_resp_fault  in  1  walker result.
REQ-014 flush_valid  in  1; flush_asid_only  in  1; flush_asid  in  ASID_BITS  sfence.vma request.

Function
REQ-015 States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT; lookup_ready = (state==IDLE) & ~flush_valid.
REQ-016 Set index = lookup_vpn[log2(SETS)-1:0] (zero bits when SETS=1); tag = remaining VPN bits plus ASID.
REQ-017 Accept: IDLE->LOOKUP, request registered; LOOKUP compares all ways of the set combinationally.
REQ-018 Entry matches when valid, tag equal, and (ASID equal or entry G=1).
REQ-019 Hit: resp_valid=1, resp_hit=1, resp_ppn/resp_perm from hit way in the cycle after acceptance; PLRU updated; ->IDLE.
REQ-020 Miss: ->MISS_REQ; walk_req_valid held high, walk_req_vpn stable, until walk_req_ready; then ->MISS_WAIT.
REQ-021 MISS_WAIT, walk_resp_valid & walk_resp_fault: resp_valid=1, resp_hit=0, resp_ppn=0, no fill, ->IDLE.
REQ-022 MISS_WAIT, walk_resp_valid & ~fault: victim written with VPN, ASID, PPN, perm; resp_valid=1, resp_hit=1 with walker data same cycle; ->IDLE.
REQ-023 Victim = lowest-index invalid way, else tree-PLRU victim; PLRU (WAYS-1 bits per set) set to point away from way hit or filled.
REQ-024 walk_resp_valid outside MISS_WAIT ignored.
REQ-025 Full flush clears every valid bit on the next edge; PLRU bits unchanged.
REQ-026 Flush during LOOKUP: response uses pre-flush contents, PLRU update suppressed.
REQ-027 Flush during MISS_REQ/MISS_WAIT: walk proceeds, response returned, but fill discarded.
REQ-028 resp_valid is never high for more than one consecutive cycle per request; outputs other than resp_* hold 0 when not in use.

Reset
REQ-029 reset=0 at an edge: state IDLE, all valid and PLRU bits 0, resp_valid, walk_req_valid 0, resp_ppn, resp_perm 0.
REQ-030 Reset mid-walk abandons the walk; walk_req_valid low the cycle after; subsequent walk_resp ignored.

Configuration
REQ-031 Macro TLB_ASID_FLUSH_EN defined: flush_valid & flush_asid_only clears only entries with G=0 and ASID==flush_asid; flush_asid_only=0 is full flush.
REQ-032 Macro undefined: flush_asid_only and flush_asid ignored; every flush is full flush.

Verification
REQ-033 Cold lookup VPN=0x00010, ASID=1 -> walk_req_vpn=0x00010; walker PPN=0xABCDE, perm=0xCF -> resp_hit=1, ppn=0xABCDE; repeat -> hit one cycle after accept, no walk.
REQ-034 Fill 5 VPNs 0x0,0x4,0x8,0xC,0x10 (set 0, 4 ways) -> fifth evicts PLRU victim VPN 0x0; lookup 0x0 misses, 0x10 hits.
REQ-035 Walker returns fault for VPN 0x20 -> resp_valid=1, resp_hit=0; next lookup 0x20 re-issues walk.
REQ-036 With TLB_ASID_FLUSH_EN: entries ASID 1 (G=0), ASID 2 (G=0), ASID 1 (G=1); flush ASID 1 -> only first misses; without macro all three miss.
REQ-037 Flush asserted during MISS_WAIT -> response hit=1 with walker PPN, next lookup same VPN misses.
REQ-038 reset=0 held one cycle in MISS_REQ -> walk_req_valid=0 next cycle, lookup_ready=1, prior entries all miss.
